// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the double-buffered VGA frame buffer.
package fb_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned FB_DEPTH  = H_RES * V_RES;
  localparam int unsigned FB_ADDR_W = $clog2(FB_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CLEAR     = 2'd1,
    S_SWAP_WAIT = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_bank.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
module fb_bank #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 307200,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter string       INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_dual.sv
// Double-buffered frame buffer: front bank scanned out, back bank drawn/cleared,
// front/back exchange deferred to the next frame_start so the display never tears.
module frame_buffer_dual #(
  parameter int unsigned       DATA_W      = fb_pkg::DATA_W,
  parameter int unsigned       H_RES       = fb_pkg::H_RES,
  parameter int unsigned       V_RES       = fb_pkg::V_RES,
  parameter int unsigned       DEPTH       = H_RES * V_RES,
  parameter int unsigned       ADDR_W      = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0,
  parameter string             INIT_FILE   = ""
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_start,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_ack,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              front_sel
);

  import fb_pkg::*;

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              swap_latched_q, swap_latched_d;
  logic              front_sel_q, front_sel_d;
  logic              swap_ack_q, swap_ack_d;
  logic              rd_sel_q, rd_zero_q;

  logic              clearing, clear_last, wr_in_range, rd_in_range;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign clearing    = (state_q == S_CLEAR);
  assign clear_last  = (clr_cnt_q == ADDR_W'(DEPTH - 1));
  assign wr_in_range = {1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH);
  assign rd_in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    swap_latched_d = swap_latched_q;
    front_sel_d    = front_sel_q;
    swap_ack_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d        = S_CLEAR;
          clr_cnt_d      = '0;
          swap_latched_d = swap_req;
        end else if (swap_req) begin
          state_d = S_SWAP_WAIT;
        end
      end
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (swap_req) swap_latched_d = 1'b1;
        if (clear_last) begin
          clr_cnt_d      = '0;
          swap_latched_d = 1'b0;
          state_d        = (swap_latched_q || swap_req) ? S_SWAP_WAIT : S_IDLE;
        end
      end
      S_SWAP_WAIT: begin
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          swap_ack_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      clr_cnt_q      <= '0;
      swap_latched_q <= 1'b0;
      front_sel_q    <= 1'b0;
      swap_ack_q     <= 1'b0;
      rd_sel_q       <= 1'b0;
      rd_zero_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      swap_latched_q <= swap_latched_d;
      front_sel_q    <= front_sel_d;
      swap_ack_q     <= swap_ack_d;
      // Bank choice is frozen with the address so a flip can't corrupt the read.
      rd_sel_q       <= front_sel_q;
      rd_zero_q      <= ~rd_in_range;
    end
  end

  // Back bank is ~front_sel_q as it stood before the edge.
  assign bank_we    = clearing | (wr_en & wr_in_range);
  assign bank_waddr = clearing ? clr_cnt_q : wr_addr;
  assign bank_wdata = clearing ? CLEAR_COLOR : wr_data;

  fb_bank #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_bank0 (
    .clk_i  (Clk),
    .we_i   (bank_we & front_sel_q),
    .waddr_i(bank_waddr),
    .wdata_i(bank_wdata),
    .raddr_i(rd_addr),
    .rdata_o(rdata0)
  );

  fb_bank #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE("")
  ) u_bank1 (
    .clk_i  (Clk),
    .we_i   (bank_we & ~front_sel_q),
    .waddr_i(bank_waddr),
    .wdata_i(bank_wdata),
    .raddr_i(rd_addr),
    .rdata_o(rdata1)
  );

  assign rd_data      = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);
  assign wr_ready     = ~clearing;
  assign clear_busy   = clearing;
  assign swap_pending = (state_q == S_SWAP_WAIT);
  assign swap_ack     = swap_ack_q;
  assign front_sel    = front_sel_q;

endmodule
